// File: rtl/wb_pkg.sv
// Writeback stage shared definitions: source selects,
// architectural register names and FSM state encoding.
package wb_pkg;

   localparam logic [2:0] WB_SEL_ALU   = 3'd0;
   localparam logic [2:0] WB_SEL_MEM   = 3'd1;
   localparam logic [2:0] WB_SEL_PC    = 3'd2;
   localparam logic [2:0] WB_SEL_FLAGS = 3'd3;
   localparam logic [2:0] WB_SEL_SPU   = 3'd4;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SPU  = 5'd27;
   localparam logic [4:0] REG_LINK = 5'd31;

   typedef enum logic {
      IDLE,
      WAIT_SPU
   } wb_state_t;

endpackage

// File: rtl/wb_data_mux.sv
// Writeback result select across ALU, load, link, flag and SPU
// sources; reserved selects report sel_ok=0.
module wb_data_mux
   import wb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] pc_link,
   input  logic              flag_bit,
   input  logic [DATA_W-1:0] spu_result,
   output logic [DATA_W-1:0] data,
   output logic              sel_ok
);

   always_comb begin
      data   = '0;
      sel_ok = 1'b1;
      unique case (1'b1)
         (sel == WB_SEL_ALU):   data = alu_result;
         (sel == WB_SEL_MEM):   data = mem_rdata;
         (sel == WB_SEL_PC):    data = pc_link;
         (sel == WB_SEL_FLAGS): data = {{(DATA_W-1){1'b0}}, flag_bit};
         (sel == WB_SEL_SPU):   data = spu_result;
         default:               sel_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registered register-file write port and
// SPU hold-off FSM with watchdog.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int                DATA_W        = 32,
   parameter int                SPU_TIMEOUT   = 256,
   parameter logic [DATA_W-1:0] SPU_ERR_VALUE = DATA_W'(32'hFFFF_FFFF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [4:0]        wb_reg,
   input  logic              wb_en,
   input  logic [2:0]        wb_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] pc_link,
   input  logic              flag_bit,
   input  logic              spu_done,
   input  logic [DATA_W-1:0] spu_result,
   output logic              spu_ack,
   output logic              stall,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              spu_timeout
);

   localparam int CNT_W = $clog2(SPU_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPU_TIMEOUT - 1);

   wb_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        reg_q, reg_d;
   logic [DATA_W-1:0] mux_data;
   logic              sel_ok;
   logic              wr_req;
   logic [4:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              ack_c, tmo_c;

   wb_data_mux #(.DATA_W(DATA_W)) u_mux (
      .sel        (wb_sel),
      .alu_result (alu_result),
      .mem_rdata  (mem_rdata),
      .pc_link    (pc_link),
      .flag_bit   (flag_bit),
      .spu_result (spu_result),
      .data       (mux_data),
      .sel_ok     (sel_ok)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      reg_d   = reg_q;
      wr_req  = 1'b0;
      wr_addr = wb_reg;
      wr_data = mux_data;
      ack_c   = 1'b0;
      tmo_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && wb_en && sel_ok) begin
               if (wb_sel != WB_SEL_SPU) begin
                  wr_req = 1'b1;
               end else if (spu_done) begin
                  wr_req = 1'b1;
                  ack_c  = 1'b1;
               end else begin
                  state_d = WAIT_SPU;
                  cnt_d   = '0;
                  reg_d   = wb_reg;
               end
            end
         end
         WAIT_SPU: begin
            wr_addr = reg_q;
            if (spu_done) begin
               wr_req  = 1'b1;
               wr_data = spu_result;
               ack_c   = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               // abandon the SPU op and poison the destination
               wr_req  = 1'b1;
               wr_data = SPU_ERR_VALUE;
               ack_c   = 1'b1;
               tmo_c   = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reg_q    <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         reg_q   <= reg_d;
         rf_we   <= wr_req && (wr_addr != REG_ZERO);
         if (wr_req && (wr_addr != REG_ZERO)) begin
            rf_waddr <= wr_addr;
            rf_wdata <= wr_data;
         end
      end
   end

   assign stall       = (state_q == WAIT_SPU);
   assign spu_ack     = ack_c && rst_n;
   assign spu_timeout = tmo_c && rst_n;

endmodule
